// File: rtl/led_blink_ctrl.sv
// Multi-channel programmable LED driver: a shared prescaler produces a timebase tick,
// and each channel runs OFF, ON, BLINK or one-shot PULSE from its own half-period.
module led_blink_ctrl #(
  parameter int CH_NUM   = 4,
  parameter int CNT_W    = 16,
  parameter int TICK_DIV = 50_000,
  localparam int CH_W    = (CH_NUM > 1) ? $clog2(CH_NUM) : 1,
  localparam int DIV_W   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [1:0]        cfg_mode,
  input  logic [CNT_W-1:0]  cfg_half,
  output logic              tick,
  output logic [CH_NUM-1:0] led_out,
  output logic [CH_NUM-1:0] pulse_done
);

  typedef enum logic [1:0] {
    MODE_OFF   = 2'b00,
    MODE_ON    = 2'b01,
    MODE_BLINK = 2'b10,
    MODE_PULSE = 2'b11
  } mode_e;

  logic [DIV_W-1:0] presc;
  logic             presc_wrap;
  logic             wr_valid;
  logic [CNT_W-1:0] half_wr;

  assign presc_wrap = (presc == DIV_W'(TICK_DIV - 1));

  // Free-running prescaler; config writes never disturb the timebase.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      presc <= '0;
      tick  <= 1'b0;
    end else begin
      presc <= presc_wrap ? '0 : presc + 1'b1;
      tick  <= presc_wrap;
    end
  end

  assign wr_valid = cfg_we && (32'(cfg_ch) < 32'(CH_NUM));
  assign half_wr  = (cfg_half == '0) ? CNT_W'(1) : cfg_half;

  for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
    mode_e            mode_q, mode_d;
    logic [CNT_W-1:0] half_q, half_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             led_q, led_d;
    logic             done_q, done_d;
    logic             sel;
    logic             at_end;

    assign sel    = wr_valid && (cfg_ch == CH_W'(i));
    assign at_end = (cnt_q == half_q - 1'b1);

    // A write to this channel takes priority over a coincident tick.
    always_comb begin
      mode_d = mode_q;
      half_d = half_q;
      cnt_d  = cnt_q;
      led_d  = led_q;
      done_d = 1'b0;
      if (sel) begin
        mode_d = mode_e'(cfg_mode);
        half_d = half_wr;
        cnt_d  = '0;
        led_d  = (cfg_mode != MODE_OFF);
      end else if (tick) begin
        unique case (mode_q)
          MODE_BLINK: begin
            if (at_end) begin
              cnt_d = '0;
              led_d = ~led_q;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          MODE_PULSE: begin
            if (at_end) begin
              cnt_d  = '0;
              led_d  = 1'b0;
              mode_d = MODE_OFF;
              done_d = 1'b1;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          default: cnt_d = '0;
        endcase
      end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
        mode_q <= MODE_OFF;
        half_q <= CNT_W'(1);
        cnt_q  <= '0;
        led_q  <= 1'b0;
        done_q <= 1'b0;
      end else begin
        mode_q <= mode_d;
        half_q <= half_d;
        cnt_q  <= cnt_d;
        led_q  <= led_d;
        done_q <= done_d;
      end
    end

    assign led_out[i]    = led_q;
    assign pulse_done[i] = done_q;
  end

endmodule

// File: tb/tb_led_blink_ctrl.sv
// Bench for led_blink_ctrl: tick-count reference model compared every cycle against a
// 4-channel and a 3-channel instance, plus hand-computed timing expectations.
module tb_led_blink_ctrl;
  localparam int TICK_DIV = 4;

  logic       sys_clk   = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       cfg_we    = 1'b0;
  logic [1:0] cfg_ch    = '0;
  logic [1:0] cfg_mode  = '0;
  logic [7:0] cfg_half  = '0;
  logic       tick_a, tick_b;
  logic [3:0] led_a, done_a;
  logic [2:0] led_b, done_b;

  int checks = 0;
  int fails  = 0;

  always #10 sys_clk = ~sys_clk;

  led_blink_ctrl #(.CH_NUM(4), .CNT_W(8), .TICK_DIV(TICK_DIV)) u_dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_mode(cfg_mode), .cfg_half(cfg_half), .tick(tick_a), .led_out(led_a),
    .pulse_done(done_a));

  // Three channels: cfg_ch == 3 must be ignored here.
  led_blink_ctrl #(.CH_NUM(3), .CNT_W(8), .TICK_DIV(TICK_DIV)) u_dut3 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_mode(cfg_mode), .cfg_half(cfg_half), .tick(tick_b), .led_out(led_b),
    .pulse_done(done_b));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each channel counts ticks k since its last write.
  int cyc;
  bit m_tick, m_tk_prev;
  int m_mode [2][4];
  int m_half [2][4];
  int m_k    [2][4];
  bit m_led  [2][4];
  bit m_done [2][4];
  int nch    [2] = '{4, 3};

  always @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cyc = 0;
      m_tick = 1'b0;
      for (int u = 0; u < 2; u++)
        for (int c = 0; c < 4; c++) begin
          m_mode[u][c] = 0; m_half[u][c] = 1; m_k[u][c] = 0;
          m_led[u][c] = 1'b0; m_done[u][c] = 1'b0;
        end
    end else begin
      m_tk_prev = m_tick;
      cyc++;
      m_tick = (cyc % TICK_DIV == 0);
      for (int u = 0; u < 2; u++)
        for (int c = 0; c < nch[u]; c++) begin
          if (cfg_we && int'(cfg_ch) == c) begin
            m_mode[u][c] = int'(cfg_mode);
            m_half[u][c] = (cfg_half == 0) ? 1 : int'(cfg_half);
            m_k[u][c]    = 0;
            m_led[u][c]  = (cfg_mode != 2'd0);
            m_done[u][c] = 1'b0;
          end else begin
            m_done[u][c] = 1'b0;
            if (m_tk_prev) begin
              m_k[u][c]++;
              if (m_mode[u][c] == 2) begin
                m_led[u][c] = ((m_k[u][c] / m_half[u][c]) % 2) == 0;
              end else if (m_mode[u][c] == 3 && m_k[u][c] == m_half[u][c]) begin
                m_led[u][c]  = 1'b0;
                m_done[u][c] = 1'b1;
                m_mode[u][c] = 0;
              end
            end
          end
        end
    end
  end

  function automatic logic [3:0] exp_led(int u);
    logic [3:0] v = '0;
    for (int c = 0; c < nch[u]; c++) v[c] = m_led[u][c];
    return v;
  endfunction

  function automatic logic [3:0] exp_done(int u);
    logic [3:0] v = '0;
    for (int c = 0; c < nch[u]; c++) v[c] = m_done[u][c];
    return v;
  endfunction

  always @(negedge sys_clk) begin
    if (sys_rst_n) begin
      check("tick_a", tick_a, m_tick);
      check("tick_b", tick_b, m_tick);
      check("led_a", led_a, exp_led(0));
      check("done_a", done_a, exp_done(0));
      check("led_b", {1'b0, led_b}, exp_led(1));
      check("done_b", {1'b0, done_b}, exp_done(1));
    end
  end

  task automatic wr(input logic [1:0] ch, input logic [1:0] md, input logic [7:0] h);
    cfg_we = 1'b1; cfg_ch = ch; cfg_mode = md; cfg_half = h;
    @(negedge sys_clk);
    cfg_we = 1'b0;
  endtask

  task automatic wait_tick();
    int n = 0;
    while (tick_a !== 1'b1 && n < 10) begin
      @(negedge sys_clk);
      n++;
    end
    check("wait_tick", tick_a, 1'b1);
  endtask

  logic prev_l;

  initial begin
    int n, toggles, r;
    repeat (5) @(negedge sys_clk);
    check("rst_led", led_a, 0);
    check("rst_done", done_a, 0);
    check("rst_tick", tick_a, 0);
    sys_rst_n = 1'b1;

    // First tick on the 4th edge after release, then every 4 cycles.
    for (int e = 1; e <= 8; e++) begin
      @(negedge sys_clk);
      check("tick_phase", tick_a, (e % 4 == 0));
    end

    // BLINK half=3 written in a tick cycle: write wins, toggles every 12 cycles.
    wait_tick();
    wr(2'd0, 2'd2, 8'd3);
    check("blink_start", led_a[0], 1'b1);
    for (int t = 0; t < 8; t++) begin
      prev_l = led_a[0];
      n = 0;
      do begin
        @(negedge sys_clk);
        n++;
      end while (led_a[0] == prev_l && n < 30);
      check("blink_interval", n, 12);
      check("blink_level", led_a[0], (t % 2 == 0) ? 1'b0 : 1'b1);
    end

    // PULSE half=2 aligned to a tick: lit exactly 8 cycles, one done strobe.
    wait_tick();
    wr(2'd1, 2'd3, 8'd2);
    check("pulse_start", led_a[1], 1'b1);
    n = 0;
    do begin
      @(negedge sys_clk);
      n++;
    end while (led_a[1] == 1'b1 && n < 20);
    check("pulse_len", n, 8);
    check("pulse_done_hi", done_a[1], 1'b1);
    @(negedge sys_clk);
    check("pulse_done_lo", done_a[1], 1'b0);
    repeat (10) @(negedge sys_clk);
    check("pulse_stays_off", led_a[1], 1'b0);

    // ON then OFF, then half=0 behaves as half=1.
    wr(2'd2, 2'd1, 8'd7);
    check("ch2_on", led_a[2], 1'b1);
    wr(2'd2, 2'd0, 8'd7);
    check("ch2_off", led_a[2], 1'b0);
    wr(2'd3, 2'd2, 8'd0);
    toggles = 0;
    prev_l = led_a[3];
    for (int i = 0; i < 40; i++) begin
      @(negedge sys_clk);
      if (led_a[3] != prev_l) toggles++;
      prev_l = led_a[3];
    end
    check("half0_toggles", toggles, 10);

    // Out-of-range channel on the 3-channel instance changes nothing.
    wr(2'd0, 2'd0, 8'd1);
    wr(2'd1, 2'd0, 8'd1);
    wr(2'd2, 2'd0, 8'd1);
    wr(2'd3, 2'd1, 8'd1);
    check("bad_ch_led_b", led_b, 3'b000);
    check("bad_ch_done_b", done_b, 3'b000);
    check("ch3_on_a", led_a[3], 1'b1);

    // Randomized traffic, including idle cycles with junk on the config bus.
    for (int i = 0; i < 1500; i++) begin
      cfg_we   = ($urandom_range(0, 4) == 0);
      cfg_ch   = 2'($urandom_range(0, 3));
      cfg_mode = 2'($urandom_range(0, 3));
      r        = $urandom_range(0, 9);
      cfg_half = (r < 3) ? 8'(r) : (r == 9) ? 8'd255 : 8'($urandom_range(1, 6));
      @(negedge sys_clk);
    end
    cfg_we = 1'b0;

    // Reset between edges mid-BLINK / mid-PULSE.
    wr(2'd0, 2'd2, 8'd2);
    wr(2'd1, 2'd3, 8'd5);
    repeat (6) @(negedge sys_clk);
    #5 sys_rst_n = 1'b0;
    #2;
    check("async_rst_led_a", led_a, 0);
    check("async_rst_led_b", led_b, 0);
    check("async_rst_done", done_a, 0);
    check("async_rst_tick", tick_a, 0);
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge sys_clk);
      if (done_a != 0 || done_b != 0 || led_a != 0) n++;
    end
    check("no_activity_after_rst", n, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
